// File: rtl/fetch_queue.sv
// Decoupled instruction fetch: owns the fetch PC, issues credit-limited memory requests and
// buffers PC-tagged responses for the core. Optional macro FETCH_BYPASS_EN enables empty-queue bypass.
module fetch_queue #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

  typedef enum logic [0:0] {S_FETCH = 1'b0, S_FLUSH = 1'b1} state_t;

  state_t                r_state, w_state_next;
  logic [ADDR_WIDTH-1:0] r_fetch_pc, w_fetch_pc_next;
  logic [ADDR_WIDTH-1:0] r_rsp_pc, w_rsp_pc_next;
  logic [CW-1:0]         r_count, w_count_next;
  logic [CW-1:0]         r_outstanding, w_outstanding_next;
  logic [CW-1:0]         r_discard_cnt, w_discard_next;
  logic [PW-1:0]         r_rd_ptr, r_wr_ptr;
  logic [DATA_WIDTH-1:0] r_data_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_pc_mem [DEPTH];

  logic [CW:0]           w_credit;
  logic [ADDR_WIDTH-1:0] w_target;
  logic                  w_req_fire, w_rsp_fetch, w_push, w_pop, w_fifo_valid, w_bypass;

  assign w_target     = redirect_pc & ~ADDR_WIDTH'(3);
  assign w_credit     = {1'b0, r_count} + {1'b0, r_outstanding};
  assign w_fifo_valid = (r_count != '0);

  // Queue slots plus in-flight requests never exceed DEPTH, so a response always has room.
  assign mem_req_valid = !rst && !redirect && (r_state == S_FETCH) && (w_credit < (CW+1)'(DEPTH));
  assign mem_req_addr  = r_fetch_pc;
  assign w_req_fire    = mem_req_valid && mem_req_ready;

`ifdef FETCH_BYPASS_EN
  assign w_bypass = !rst && !redirect && (r_state == S_FETCH) && !w_fifo_valid && mem_rsp_valid;
`else
  assign w_bypass = 1'b0;
`endif

  assign instr_valid = !rst && (w_fifo_valid || w_bypass);
  assign instr       = w_fifo_valid ? r_data_mem[r_rd_ptr] : (w_bypass ? mem_rsp_data : '0);
  assign instr_pc    = w_fifo_valid ? r_pc_mem[r_rd_ptr] : r_rsp_pc;

  assign w_rsp_fetch = mem_rsp_valid && !redirect && (r_state == S_FETCH);
  assign w_pop       = w_fifo_valid && instr_ready && !redirect;
  assign w_push      = w_rsp_fetch && !(w_bypass && instr_ready);

  always_comb begin
    w_state_next       = r_state;
    w_fetch_pc_next    = r_fetch_pc;
    w_rsp_pc_next      = r_rsp_pc;
    w_discard_next     = r_discard_cnt;
    w_outstanding_next = r_outstanding + CW'(w_req_fire) - CW'(mem_rsp_valid);
    w_count_next       = r_count + CW'(w_push) - CW'(w_pop);
    if (redirect) begin
      // No request is accepted under redirect, so what remains in flight must all be discarded.
      w_fetch_pc_next = w_target;
      w_rsp_pc_next   = w_target;
      w_count_next    = '0;
      w_discard_next  = w_outstanding_next;
      w_state_next    = (w_outstanding_next != '0) ? S_FLUSH : S_FETCH;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_req_fire)    w_fetch_pc_next = r_fetch_pc + PC_STEP;
          if (mem_rsp_valid) w_rsp_pc_next   = r_rsp_pc + PC_STEP;
        end
        S_FLUSH: begin
          if (mem_rsp_valid) w_discard_next = r_discard_cnt - CW'(1);
          if (w_discard_next == '0) w_state_next = S_FETCH;
        end
        default: w_state_next = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_FETCH;
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_count       <= '0;
      r_outstanding <= '0;
      r_discard_cnt <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
    end else begin
      r_state       <= w_state_next;
      r_fetch_pc    <= w_fetch_pc_next;
      r_rsp_pc      <= w_rsp_pc_next;
      r_count       <= w_count_next;
      r_outstanding <= w_outstanding_next;
      r_discard_cnt <= w_discard_next;
      if (redirect) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    always_ff @(posedge clk) begin
      if (w_push && (r_wr_ptr == PW'(gi))) begin
        r_data_mem[gi] <= mem_rsp_data;
        r_pc_mem[gi]   <= r_rsp_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push && !w_pop) assert (r_count != CW'(DEPTH));
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: variable-latency in-order memory model, request/pop logs,
// one task per scenario. Expected values are hand-computed (optionally for FETCH_BYPASS_EN).
module tb_fetch_queue;
`ifdef FETCH_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  always #5 clk = ~clk;

  fetch_queue #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
  );

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t       mq[$];
  logic [31:0] req_addr[$];
  int          req_cyc[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_data[$];
  int          pop_cyc[$];
  int cyc, lat, first_valid;
  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic settle();
    #1;
  endtask

  task automatic drive_rsp();
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mem_word(mq[0].addr);
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
    end
  endtask

  // One clock cycle: log handshakes before the edge, then advance the memory model.
  task automatic step();
    logic fire, rv;
    logic [31:0] a;
    mreq_t m;
    #1;
    fire = mem_req_valid && mem_req_ready;
    a    = mem_req_addr;
    rv   = mem_rsp_valid;
    if (instr_valid && first_valid < 0) first_valid = cyc;
    if (instr_valid && instr_ready) begin
      pop_pc.push_back(instr_pc); pop_data.push_back(instr); pop_cyc.push_back(cyc);
      $display("cyc %0d: pop pc=%h data=%h", cyc, instr_pc, instr);
    end
    if (fire) begin
      req_addr.push_back(a); req_cyc.push_back(cyc);
      $display("cyc %0d: req addr=%h", cyc, a);
    end
    @(posedge clk); #1;
    if (rv) void'(mq.pop_front());
    if (fire) begin m.addr = a; m.due = cyc + lat; mq.push_back(m); end
    cyc++;
    drive_rsp();
  endtask

  task automatic reset_assert();
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0;
    mem_req_ready = 1'b1; instr_ready = 1'b1;
    mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    mq.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    req_addr.delete(); req_cyc.delete(); pop_pc.delete(); pop_data.delete(); pop_cyc.delete();
    cyc = 0; first_valid = -1;
  endtask

  task automatic test_stream();
    reset_assert(); lat = 1; rst = 1'b0;
    repeat (8) step();
    checks++; if (first_valid !== 2 - BYP) begin errors++; $display("FAIL stream_first_valid: got %0d expected %0d", first_valid, 2 - BYP); end
    checks++;
    if (req_addr.size() < 6) begin errors++; $display("FAIL stream_req_count: got %0d expected >=6", req_addr.size()); end
    else for (int i = 0; i < 6; i++) begin
      checks++; if (req_addr[i] !== 32'(4*i) || req_cyc[i] !== i) begin errors++;
        $display("FAIL stream_req[%0d]: got addr=%h cyc=%0d expected addr=%h cyc=%0d", i, req_addr[i], req_cyc[i], 32'(4*i), i); end
    end
    checks++;
    if (pop_pc.size() < 5) begin errors++; $display("FAIL stream_pop_count: got %0d expected >=5", pop_pc.size()); end
    else for (int i = 0; i < 5; i++) begin
      checks++; if (pop_pc[i] !== 32'(4*i) || pop_data[i] !== mem_word(32'(4*i))) begin errors++;
        $display("FAIL stream_pop[%0d]: got pc=%h data=%h expected pc=%h data=%h", i, pop_pc[i], pop_data[i], 32'(4*i), mem_word(32'(4*i))); end
    end
  endtask

  // Reset asserted while streaming: outputs quiet at once, first request right after release.
  task automatic test_reset();
    rst = 1'b1; mq.delete(); mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    settle();
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid_now: got %b expected 0", mem_req_valid); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid_now: got %b expected 0", instr_valid); end
    @(posedge clk); #1;
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 00000000", instr); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr_pc: got %h expected 00000000", instr_pc); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b expected 0", instr_valid); end
    rst = 1'b0; settle();
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0) begin errors++;
      $display("FAIL reset_first_req: got valid=%b addr=%h expected valid=1 addr=00000000", mem_req_valid, mem_req_addr); end
  endtask

  task automatic test_backpressure();
    reset_assert(); lat = 1; instr_ready = 1'b0; rst = 1'b0;
    repeat (10) step();
    settle();
    checks++; if (req_addr.size() !== 4) begin errors++; $display("FAIL bp_req_count: got %0d expected 4", req_addr.size()); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid: got %b expected 0", mem_req_valid); end
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== mem_word(32'h0)) begin errors++;
      $display("FAIL bp_head: got v=%b pc=%h data=%h expected v=1 pc=00000000 data=%h", instr_valid, instr_pc, instr, mem_word(32'h0)); end
    instr_ready = 1'b1;
    repeat (12) step();
    checks++;
    if (pop_pc.size() < 5) begin errors++; $display("FAIL bp_pop_count: got %0d expected >=5", pop_pc.size()); end
    else for (int i = 0; i < 5; i++) begin
      checks++; if (pop_pc[i] !== 32'(4*i) || pop_data[i] !== mem_word(32'(4*i))) begin errors++;
        $display("FAIL bp_pop[%0d]: got pc=%h data=%h expected pc=%h", i, pop_pc[i], pop_data[i], 32'(4*i)); end
    end
    checks++;
    if (req_addr.size() < 5) begin errors++; $display("FAIL bp_resume_count: got %0d expected >=5", req_addr.size()); end
    else begin
      checks++; if (req_addr[4] !== 32'h10 || req_cyc[4] !== 11) begin errors++;
        $display("FAIL bp_resume: got addr=%h cyc=%0d expected addr=00000010 cyc=11", req_addr[4], req_cyc[4]); end
    end
  endtask

  task automatic test_redirect_flush();
    reset_assert(); lat = 3; rst = 1'b0;
    repeat (3) step();
    redirect = 1'b1; redirect_pc = 32'h103;
    step();
    redirect = 1'b0; settle();
    checks++; if (instr_valid !== 1'b0 || mem_req_valid !== 1'b0) begin errors++;
      $display("FAIL flush_quiet: got instr_valid=%b req_valid=%b expected 0 0", instr_valid, mem_req_valid); end
    repeat (12) step();
    checks++;
    if (req_addr.size() < 5) begin errors++; $display("FAIL flush_req_count: got %0d expected >=5", req_addr.size()); end
    else begin
      checks++; if (req_addr[2] !== 32'h8 || req_addr[3] !== 32'h100 || req_cyc[3] !== 6) begin errors++;
        $display("FAIL flush_req3: got addr=%h cyc=%0d prev=%h expected addr=00000100 cyc=6 prev=00000008", req_addr[3], req_cyc[3], req_addr[2]); end
      checks++; if (req_addr[4] !== 32'h104 || req_cyc[4] !== 7) begin errors++;
        $display("FAIL flush_req4: got addr=%h cyc=%0d expected addr=00000104 cyc=7", req_addr[4], req_cyc[4]); end
    end
    checks++;
    if (pop_pc.size() < 3) begin errors++; $display("FAIL flush_pop_count: got %0d expected >=3", pop_pc.size()); end
    else begin
      checks++; if (pop_cyc[0] !== 10 - BYP) begin errors++; $display("FAIL flush_pop_cyc: got %0d expected %0d", pop_cyc[0], 10 - BYP); end
      for (int i = 0; i < pop_pc.size(); i++) begin
        checks++; if (pop_pc[i] !== 32'h100 + 32'(4*i) || pop_data[i] !== mem_word(32'h100 + 32'(4*i))) begin errors++;
          $display("FAIL flush_pop[%0d]: got pc=%h data=%h expected pc=%h", i, pop_pc[i], pop_data[i], 32'h100 + 32'(4*i)); end
      end
    end
  endtask

  task automatic test_redirect_rsp_pop();
    reset_assert(); lat = 2; rst = 1'b0;
    repeat (3) step();
    redirect = 1'b1; redirect_pc = 32'h40; settle();
    checks++; if (instr_valid !== (BYP ? 1'b0 : 1'b1)) begin errors++;
      $display("FAIL rrp_valid_at_redirect: got %b expected %b", instr_valid, (BYP ? 1'b0 : 1'b1)); end
    step();
    redirect = 1'b0; settle();
    checks++; if (instr_valid !== 1'b0 || mem_req_valid !== 1'b0) begin errors++;
      $display("FAIL rrp_next_cycle: got instr_valid=%b req_valid=%b expected 0 0", instr_valid, mem_req_valid); end
    repeat (6) step();
    checks++;
    if (req_addr.size() < 4) begin errors++; $display("FAIL rrp_req_count: got %0d expected >=4", req_addr.size()); end
    else begin
      checks++; if (req_addr[3] !== 32'h40 || req_cyc[3] !== 5) begin errors++;
        $display("FAIL rrp_req: got addr=%h cyc=%0d expected addr=00000040 cyc=5", req_addr[3], req_cyc[3]); end
    end
    checks++;
    if (pop_pc.size() < 2) begin errors++; $display("FAIL rrp_pop_count: got %0d expected >=2", pop_pc.size()); end
    else begin
      checks++; if (pop_pc[0] !== 32'h0 || pop_pc[1] !== 32'h40 || pop_data[1] !== mem_word(32'h40)) begin errors++;
        $display("FAIL rrp_pops: got pc0=%h pc1=%h data1=%h expected pc0=00000000 pc1=00000040 data1=%h", pop_pc[0], pop_pc[1], pop_data[1], mem_word(32'h40)); end
    end
  endtask

  task automatic test_req_stall();
    reset_assert(); lat = 1; rst = 1'b0;
    repeat (2) step();
    mem_req_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      settle();
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8) begin errors++;
        $display("FAIL stall_hold[%0d]: got valid=%b addr=%h expected valid=1 addr=00000008", k, mem_req_valid, mem_req_addr); end
      step();
    end
    mem_req_ready = 1'b1;
    step();
    checks++;
    if (req_addr.size() !== 3) begin errors++; $display("FAIL stall_req_count: got %0d expected 3", req_addr.size()); end
    else begin
      checks++; if (req_addr[2] !== 32'h8 || req_cyc[2] !== 7) begin errors++;
        $display("FAIL stall_accept: got addr=%h cyc=%0d expected addr=00000008 cyc=7", req_addr[2], req_cyc[2]); end
    end
  endtask

  task automatic test_pc_wrap();
    reset_assert(); lat = 1; rst = 1'b0;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    step();
    redirect = 1'b0;
    repeat (6) step();
    checks++;
    if (req_addr.size() < 3) begin errors++; $display("FAIL wrap_req_count: got %0d expected >=3", req_addr.size()); end
    else begin
      checks++; if (req_addr[0] !== 32'hFFFF_FFFC || req_cyc[0] !== 1 || req_addr[1] !== 32'h0 || req_addr[2] !== 32'h4) begin errors++;
        $display("FAIL wrap_reqs: got %h@%0d %h %h expected FFFFFFFC@1 00000000 00000004", req_addr[0], req_cyc[0], req_addr[1], req_addr[2]); end
    end
    checks++;
    if (pop_pc.size() < 2) begin errors++; $display("FAIL wrap_pop_count: got %0d expected >=2", pop_pc.size()); end
    else begin
      checks++; if (pop_pc[0] !== 32'hFFFF_FFFC || pop_pc[1] !== 32'h0 || pop_data[1] !== mem_word(32'h0)) begin errors++;
        $display("FAIL wrap_pops: got pc0=%h pc1=%h data1=%h expected FFFFFFFC 00000000 %h", pop_pc[0], pop_pc[1], pop_data[1], mem_word(32'h0)); end
    end
  endtask

  initial begin
    test_stream();
    test_reset();
    test_backpressure();
    test_redirect_flush();
    test_redirect_rsp_pop();
    test_req_stall();
    test_pc_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch front-end that sits directly upstream of the single-cycle core's decode/regfile stage. It replaces the combinational PC/ROM pair with a decoupled fetch path.
- Owns the fetch PC and issues word-aligned requests to an instruction memory with variable, in-order response latency.
- Buffers returned instructions, tagged with their PC, in a small FIFO and presents them to the core with a valid/ready handshake.
- Branch redirects from the control unit flush the queue and discard stale in-flight responses.

Parameters:
- DATA_WIDTH, 32, instruction width.
- ADDR_WIDTH, 32, PC / memory address width.
- DEPTH, 4, FIFO entries; also the maximum of FIFO occupancy plus outstanding requests (power of 2, ≥2).
- RESET_PC, 32'h0, PC of the first fetch after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- redirect  in  1  branch/jump taken (PCsrc).
- redirect_pc  in  ADDR_WIDTH  target PC; bits [1:0] ignored and forced to 0.
- mem_req_valid  out  1  fetch request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  ADDR_WIDTH  fetch address.
- mem_rsp_valid  in  1  response valid; responses return in request order, never before the accepting cycle +1.
- mem_rsp_data  in  DATA_WIDTH  fetched instruction.
- instr_valid  out  1  instruction available to the core.
- instr_ready  in  1  core consumes the instruction.
- instr  out  DATA_WIDTH  head instruction.
- instr_pc  out  ADDR_WIDTH  PC of the head instruction.

Behaviour:
- Reset:
  - fetch_pc=RESET_PC, rsp_pc=RESET_PC, FIFO empty, outstanding=0, discard_cnt=0, state=FETCH.
  - Outputs: mem_req_valid=0 during the reset cycle, instr_valid=0, instr=0, instr_pc=RESET_PC.
  - Reset mid-operation drops everything. Responses to requests issued before reset are the environment's responsibility (memory is reset together).
- States: FETCH and FLUSH.
  - FETCH: mem_req_valid = !redirect && (count+outstanding < DEPTH). mem_req_addr = fetch_pc.
  - Accept (valid&&ready): outstanding+1, fetch_pc+4 (wraps modulo 2^ADDR_WIDTH).
  - Address held stable while valid && !ready.
  - FLUSH: mem_req_valid=0. Every response decrements discard_cnt and outstanding and is dropped. Transition to FETCH in the cycle after discard_cnt reaches 0.
- Response in FETCH:
  - Push {mem_rsp_data, rsp_pc}; rsp_pc+4; outstanding-1.
  - The credit rule guarantees the FIFO never overflows. A push when full is an assertion failure.
- Pop: instr_valid && instr_ready removes the head. Push and pop in the same cycle on a full or empty FIFO are legal; count is unchanged.
- Redirect (highest priority, any state):
  - FIFO cleared.
  - fetch_pc = rsp_pc = {redirect_pc[ADDR_WIDTH-1:2],2'b00}.
  - discard_cnt = outstanding after this cycle's events (a response arriving this cycle is consumed and dropped; no request is accepted this cycle).
  - Next state is FLUSH if discard_cnt>0, else FETCH.
  - instr_valid=0 in the following cycle. A pop coinciding with redirect has no further effect.
  - A redirect while in FLUSH re-targets the PC and keeps discard_cnt consistent with outstanding.
- Latency: without bypass, a response appears on instr_valid the cycle after mem_rsp_valid. First request issues the first cycle after rst deasserts.
- Widths: count and outstanding are $clog2(DEPTH+1) bits. PC arithmetic is unsigned modulo.

Optional Feature:
- FETCH_BYPASS_EN.
- Defined: when the FIFO is empty, state=FETCH and mem_rsp_valid, the response drives instr/instr_pc/instr_valid combinationally in the same cycle. If instr_ready is also high, it is consumed without being pushed. Zero-cycle fetch-to-core latency.
- Undefined: all instructions pass through the FIFO; minimum latency is 1 cycle.

Test Plan:
- Reset, RESET_PC=0, memory ready always, latency 1, instr_ready=1:
  - Requests 0x0, 0x4, 0x8… on consecutive cycles.
  - instr_pc sequence 0x0, 0x4, 0x8 with matching data.
  - instr_valid first high 2 cycles after reset release (1 with bypass).
- Backpressure: instr_ready=0 for 10 cycles, DEPTH=4:
  - Exactly 4 requests accepted, then mem_req_valid=0.
  - Releasing instr_ready drains 0x0..0xC in order, then fetching resumes at 0x10.
- Redirect to 0x103 with 3 outstanding requests (latency 3):
  - Addresses 0x100, 0x104 issue only after 3 responses are discarded.
  - No stale instruction ever appears on instr.
  - instr_pc resumes at 0x100.
- Redirect in the same cycle as a response and a pop:
  - The response is dropped and the FIFO is empty next cycle.
  - instr_valid=0 next cycle; discard_cnt equals the remaining outstanding count.
- mem_req_ready=0 for 5 cycles: mem_req_valid=1 and mem_req_addr constant (e.g. 0x8) throughout; accepted on the first ready cycle.
- PC wrap: redirect to 0xFFFFFFFC; the next request address is 0x00000000 and instr_pc follows.
